cic_rate_ctrl: RTL and testbench

CIC_RATE_CTRL -- requirements
Module: cic_rate_ctrl

---
 rtl/cic_pkg.sv | 16 +
 rtl/sync_fifo.sv | 71 +++++++
 rtl/cic_rate_ctrl.sv | 124 ++++++++++++
 tb/tb_cic_rate_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared defaults and state encoding for the CIC rate controller
// Purpose: default sample width, strobe period and FIFO depth, plus the
//          controller state enum, shared by cic_rate_ctrl and its bench.
package cic_pkg;

    localparam int CIC_W     = 18;
    localparam int CIC_R     = 2000;
    localparam int CIC_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } cic_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock sample FIFO with registered level/full/empty
// Purpose: buffers upstream samples for the CIC rate controller.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, wr_data     write request and data (ignored while full)
//   pop, rd_data      read request (ignored while empty); rd_data shows the head
//   level             registered occupancy
//   full, empty       registered flags derived from the next occupancy
module sync_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               wr_data,
    input  logic                       pop,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          full_q;
    logic          empty_q;
    logic          push_ok;
    logic          pop_ok;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Flags are registered, so a pop cannot open the full gate in its own cycle.
    assign push_ok = push && !full_q;
    assign pop_ok  = pop && !empty_q;
    assign level_d = level_q + LW'(push_ok) - LW'(pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= ptr_next(wr_ptr_q);
            if (pop_ok)  rd_ptr_q <= ptr_next(rd_ptr_q);
            level_q <= level_d;
            full_q  <= (level_d == LW'(DEPTH));
            empty_q <= (level_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_q];
    assign level   = level_q;
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/cic_rate_ctrl.sv
// rtl/cic_rate_ctrl.sv - paces buffered samples into a CIC at one per R clocks
// Purpose: accepts samples from upstream into a small FIFO and, once primed,
//          emits one sample strobe to the CIC every R clocks.
// Ports:
//   clk, ic_rst           clock, asynchronous active-high reset
//   ic_en                 stream enable; dropping it returns to IDLE
//   ic_clr                clears the sticky underflow flag
//   id_data, ic_val       upstream sample and valid
//   oc_rdy                FIFO can accept a sample
//   od_data, oc_val_data  sample and one-cycle strobe towards the CIC
//   oc_underflow          sticky: a strobe found the FIFO empty
//   od_level              FIFO occupancy
module cic_rate_ctrl
    import cic_pkg::*;
#(
    parameter int W         = CIC_W,
    parameter int R         = CIC_R,
    parameter int DEPTH     = CIC_DEPTH,
    parameter int PRIME_LVL = 2
) (
    input  logic                       clk,
    input  logic                       ic_rst,
    input  logic                       ic_en,
    input  logic                       ic_clr,
    input  logic [W-1:0]               id_data,
    input  logic                       ic_val,
    output logic                       oc_rdy,
    output logic [W-1:0]               od_data,
    output logic                       oc_val_data,
    output logic                       oc_underflow,
    output logic [$clog2(DEPTH+1)-1:0] od_level
);

    localparam int CW = $clog2(R);
    localparam int LW = $clog2(DEPTH + 1);

    cic_state_t    state_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  data_q;
    logic          val_q;
    logic          unf_q;

    logic          strobe;
    logic          fifo_full;
    logic          fifo_empty;
    logic [W-1:0]  fifo_rd_data;
    logic [LW-1:0] fifo_level;

    // A strobe is only issued while staying in RUN; disabling on the last
    // phase drops it.
    assign strobe = (state_q == ST_RUN) && ic_en && (cnt_q == CW'(R - 1));

    sync_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (ic_rst),
        .push    (ic_val),
        .wr_data (id_data),
        .pop     (strobe),
        .rd_data (fifo_rd_data),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or posedge ic_rst) begin
        if (ic_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            val_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            val_q <= strobe;
            if (ic_clr) unf_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q  <= '0;
                    data_q <= '0;
                    if (ic_en) state_q <= ST_PRIME;
                end
                ST_PRIME: begin
                    cnt_q  <= '0;
                    data_q <= '0;
                    if (!ic_en)                           state_q <= ST_IDLE;
                    else if (fifo_level >= LW'(PRIME_LVL)) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (!ic_en) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        data_q  <= '0;
                    end else if (strobe) begin
                        cnt_q <= '0;
                        // Empty FIFO still strobes (zero sample) to keep the CIC rate;
                        // the set here overrides a same-cycle clear.
                        if (fifo_empty) begin
                            data_q <= '0;
                            unf_q  <= 1'b1;
                        end else begin
                            data_q <= fifo_rd_data;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    data_q  <= '0;
                end
            endcase
        end
    end

    assign oc_rdy       = !fifo_full;
    assign od_data      = data_q;
    assign oc_val_data  = val_q;
    assign oc_underflow = unf_q;
    assign od_level     = fifo_level;

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// tb/tb_cic_rate_ctrl.sv - self-checking bench for cic_rate_ctrl
module tb_cic_rate_ctrl;

    localparam int W         = 18;
    localparam int R         = 8;
    localparam int DEPTH     = 4;
    localparam int PRIME_LVL = 2;
    localparam int LW        = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en  = 1'b0;
    logic          clr = 1'b0;
    logic          val = 1'b0;
    logic [W-1:0]  din = '0;
    logic          rdy;
    logic          vout;
    logic          unf;
    logic [W-1:0]  dout;
    logic [LW-1:0] lvl;

    always #5 clk = ~clk;

    cic_rate_ctrl #(
        .W         (W),
        .R         (R),
        .DEPTH     (DEPTH),
        .PRIME_LVL (PRIME_LVL)
    ) dut (
        .clk          (clk),
        .ic_rst       (rst),
        .ic_en        (en),
        .ic_clr       (clr),
        .id_data      (din),
        .ic_val       (val),
        .oc_rdy       (rdy),
        .od_data      (dout),
        .oc_val_data  (vout),
        .oc_underflow (unf),
        .od_level     (lvl)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: queue of buffered samples, a mode (0 idle, 1 prime,
    // 2 run) and the number of clocks spent in RUN; a strobe falls on every
    // R-th clock of RUN.
    logic [W-1:0] m_q[$];
    int           m_mode;
    int           m_run_len;
    bit           m_val;
    bit           m_unf;
    logic [W-1:0] m_data;

    function automatic void model_reset();
        m_q.delete();
        m_mode    = 0;
        m_run_len = 0;
        m_val     = 0;
        m_unf     = 0;
        m_data    = '0;
    endfunction

    function automatic void model_edge();
        int pre    = m_q.size();
        bit push   = val && (pre < DEPTH);
        bit strobe = (m_mode == 2) && en && (((m_run_len + 1) % R) == 0);
        if (clr) m_unf = 0;
        if (strobe) begin
            if (pre > 0) m_data = m_q.pop_front();
            else begin
                m_data = '0;
                m_unf  = 1;
            end
        end
        if (push) m_q.push_back(din);
        m_val = strobe;
        if (!en) m_mode = 0;
        else if (m_mode == 0) m_mode = 1;
        else if (m_mode == 1 && pre >= PRIME_LVL) begin
            m_mode    = 2;
            m_run_len = 0;
        end else if (m_mode == 2) m_run_len++;
        if (m_mode != 2) m_data = '0;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        val = 1'b0;
        clr = 1'b0;
        din = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        val = 1'b0;
        clr = 1'b0;
        model_reset();
        #1;
        n_cmp += 5;
        if (lvl !== '0)    begin n_fail++; $display("FAIL reset_level got=%0d exp=0", lvl); end
        if (rdy !== 1'b1)  begin n_fail++; $display("FAIL reset_rdy got=%b exp=1", rdy); end
        if (dout !== '0)   begin n_fail++; $display("FAIL reset_data got=%h exp=0", dout); end
        if (vout !== 1'b0) begin n_fail++; $display("FAIL reset_val got=%b exp=0", vout); end
        if (unf !== 1'b0)  begin n_fail++; $display("FAIL reset_unf got=%b exp=0", unf); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_prime_run();
        int first = -1;
        int second = -1;
        logic [W-1:0] d1 = '0;
        logic [W-1:0] d2 = '0;
        do_reset();
        val = 1'b1; din = 18'h00100; cycle();
        din = 18'h00200; cycle();
        val = 1'b0;
        en  = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            n_cmp++;
            if (vout !== m_val) begin n_fail++; $display("FAIL prime_strobe_k%0d got=%b exp=%b", k, vout, m_val); end
            if (vout === 1'b1) begin
                if (first < 0) begin first = k; d1 = dout; end
                else if (second < 0) begin second = k; d2 = dout; end
            end
        end
        n_cmp += 4;
        if (first != 10)        begin n_fail++; $display("FAIL first_strobe_cycle got=%0d exp=10", first); end
        if (second != 18)       begin n_fail++; $display("FAIL second_strobe_cycle got=%0d exp=18", second); end
        if (d1 !== 18'h00100)   begin n_fail++; $display("FAIL first_strobe_data got=%h exp=00100", d1); end
        if (d2 !== 18'h00200)   begin n_fail++; $display("FAIL second_strobe_data got=%h exp=00200", d2); end
    endtask

    task automatic test_underflow();
        bit seen = 0;
        n_cmp++;
        if (unf !== 1'b0) begin n_fail++; $display("FAIL unf_before got=%b exp=0", unf); end
        for (int k = 0; k < 12 && !seen; k++) begin
            cycle();
            if (vout === 1'b1) seen = 1;
        end
        n_cmp += 3;
        if (!seen) begin n_fail++; $display("FAIL underflow_strobe got=none exp=strobe"); end
        if (dout !== '0)  begin n_fail++; $display("FAIL underflow_data got=%h exp=0", dout); end
        if (unf !== 1'b1) begin n_fail++; $display("FAIL underflow_flag got=%b exp=1", unf); end
        clr = 1'b1; cycle(); clr = 1'b0;
        n_cmp++;
        if (unf !== 1'b0) begin n_fail++; $display("FAIL underflow_clear got=%b exp=0", unf); end
    endtask

    task automatic test_fill();
        logic [W-1:0] smp[5];
        int idx = 0;
        bit acc;
        do_reset();
        for (int i = 0; i < 5; i++) smp[i] = W'($urandom);
        for (int c = 0; c < 8; c++) begin
            val = (idx < 5);
            din = (idx < 5) ? smp[idx] : '0;
            acc = val && rdy;
            cycle();
            if (acc) idx++;
        end
        n_cmp += 4;
        if (idx != 4)          begin n_fail++; $display("FAIL fill_accepted got=%0d exp=4", idx); end
        if (rdy !== 1'b0)      begin n_fail++; $display("FAIL fill_rdy got=%b exp=0", rdy); end
        if (lvl !== LW'(4))    begin n_fail++; $display("FAIL fill_level got=%0d exp=4", lvl); end
        if (din !== smp[4])    begin n_fail++; $display("FAIL fill_held got=%h exp=%h", din, smp[4]); end
        val = 1'b0;
    endtask

    logic [W-1:0] pp_smp[3];

    task automatic test_push_pop();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pp_smp[i] = W'($urandom);
            val = 1'b1; din = pp_smp[i]; cycle();
        end
        val = 1'b0;
        en  = 1'b1;
        for (int k = 1; k <= 17; k++) cycle();
        n_cmp++;
        if (lvl !== LW'(2)) begin n_fail++; $display("FAIL pushpop_pre_level got=%0d exp=2", lvl); end
        val = 1'b1; din = W'($urandom); cycle(); val = 1'b0;
        n_cmp += 3;
        if (vout !== 1'b1)     begin n_fail++; $display("FAIL pushpop_strobe got=%b exp=1", vout); end
        if (lvl !== LW'(2))    begin n_fail++; $display("FAIL pushpop_level got=%0d exp=2", lvl); end
        if (dout !== pp_smp[1]) begin n_fail++; $display("FAIL pushpop_data got=%h exp=%h", dout, pp_smp[1]); end
    endtask

    task automatic test_disable();
        int first = -1;
        for (int k = 0; k < 5; k++) cycle();
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_cmp += 2;
            if (vout !== 1'b0) begin n_fail++; $display("FAIL disable_no_strobe_%0d got=%b exp=0", k, vout); end
            if (dout !== '0)   begin n_fail++; $display("FAIL disable_data_%0d got=%h exp=0", k, dout); end
        end
        en = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            cycle();
            if (vout === 1'b1 && first < 0) first = k;
        end
        n_cmp++;
        if (first != 10) begin n_fail++; $display("FAIL reenable_strobe_cycle got=%0d exp=10", first); end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] s0;
        do_reset();
        s0 = W'($urandom_range(1, (1 << W) - 1));
        val = 1'b1; din = s0; cycle();
        for (int i = 1; i < 4; i++) begin din = W'($urandom); cycle(); end
        val = 1'b0;
        en  = 1'b1;
        for (int k = 1; k <= 13; k++) cycle();
        n_cmp += 2;
        if (lvl !== LW'(3)) begin n_fail++; $display("FAIL midrun_pre_level got=%0d exp=3", lvl); end
        if (dout !== s0)    begin n_fail++; $display("FAIL midrun_pre_data got=%h exp=%h", dout, s0); end
        rst = 1'b1;
        #1;
        n_cmp += 5;
        if (lvl !== '0)    begin n_fail++; $display("FAIL midrun_level got=%0d exp=0", lvl); end
        if (rdy !== 1'b1)  begin n_fail++; $display("FAIL midrun_rdy got=%b exp=1", rdy); end
        if (dout !== '0)   begin n_fail++; $display("FAIL midrun_data got=%h exp=0", dout); end
        if (vout !== 1'b0) begin n_fail++; $display("FAIL midrun_val got=%b exp=0", vout); end
        if (unf !== 1'b0)  begin n_fail++; $display("FAIL midrun_unf got=%b exp=0", unf); end
        model_reset();
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            en  = ($urandom_range(0, 29) != 0);
            val = ($urandom_range(0, 6) == 0);
            clr = ($urandom_range(0, 15) == 0);
            din = W'($urandom);
            cycle();
            n_cmp += 5;
            if (dout !== m_data) begin n_fail++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, dout, m_data); end
            if (vout !== m_val)  begin n_fail++; $display("FAIL rand_val c=%0d got=%b exp=%b", c, vout, m_val); end
            if (unf !== m_unf)   begin n_fail++; $display("FAIL rand_unf c=%0d got=%b exp=%b", c, unf, m_unf); end
            if (lvl !== LW'(m_q.size())) begin n_fail++; $display("FAIL rand_level c=%0d got=%0d exp=%0d", c, lvl, m_q.size()); end
            if (rdy !== (m_q.size() < DEPTH)) begin n_fail++; $display("FAIL rand_rdy c=%0d got=%b exp=%b", c, rdy, (m_q.size() < DEPTH)); end
        end
        en = 1'b0; val = 1'b0; clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_prime_run();
        test_underflow();
        test_fill();
        test_push_pop();
        test_disable();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
